// File: rtl/armleocpu_decode_operand_if.sv
// Fetch->decode and decode->execute valid/ready channels of the decode/operand stage.
// master is the surrounding pipeline (fetch + execute side), slave is the decode stage.
interface armleocpu_decode_operand_if;
  logic        f2d_valid;
  logic        f2d_ready;
  logic [31:0] f2d_instr;
  logic [31:0] f2d_pc;
  logic        d2e_valid;
  logic        d2e_ready;
  logic [31:0] d2e_instr;
  logic [31:0] d2e_pc;
  logic [31:0] d2e_rs1_data;
  logic [31:0] d2e_rs2_data;

  modport master (
    output f2d_valid, f2d_instr, f2d_pc, d2e_ready,
    input  f2d_ready, d2e_valid, d2e_instr, d2e_pc, d2e_rs1_data, d2e_rs2_data
  );

  modport slave (
    input  f2d_valid, f2d_instr, f2d_pc, d2e_ready,
    output f2d_ready, d2e_valid, d2e_instr, d2e_pc, d2e_rs1_data, d2e_rs2_data
  );
endinterface

// File: rtl/armleocpu_decode_operand.sv
// Decode/operand-fetch stage: holds one instruction, resolves operands with writeback
// bypass, and tracks in-flight destination registers in a scoreboard.
module armleocpu_decode_operand #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        async_rst_n,
    armleocpu_decode_operand_if.slave pipe,
    output logic [4:0]  rs1_addr,
    input  logic [31:0] rs1_rdata,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs2_rdata,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_rd_wdata,
    input  logic        wb_rd_write,
    input  logic        kill
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    logic        held_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:1] pending_q;
    logic [31:1] pending_d;
    logic [31:0] pend_full;

    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        writes_rd, uses_rs1, uses_rs2;
    logic        match_1, match_2, wb_hits_rd;
    logic        raw_1, raw_2, waw, hazard;
    logic        issue, accept;

    assign rs1_addr  = instr_q[19:15];
    assign rs2_addr  = instr_q[24:20];
    assign rd        = instr_q[11:7];
    assign funct3    = instr_q[14:12];
    // x0 has no scoreboard bit; it reads as never pending
    assign pend_full = {pending_q, 1'b0};

    always_comb begin
        writes_rd = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (opcode_e'(instr_q[6:0]))
            OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_SYSTEM: begin
                writes_rd = (funct3 != 3'd0);
                uses_rs1  = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            default: ;
        endcase
        if (rd == 5'd0)
            writes_rd = 1'b0;
    end

    assign match_1    = BYPASS && wb_rd_write && (wb_rd_addr == rs1_addr) && (rs1_addr != 5'd0);
    assign match_2    = BYPASS && wb_rd_write && (wb_rd_addr == rs2_addr) && (rs2_addr != 5'd0);
    assign wb_hits_rd = wb_rd_write && (wb_rd_addr == rd);

    assign raw_1  = uses_rs1 && pend_full[rs1_addr] && !match_1;
    assign raw_2  = uses_rs2 && pend_full[rs2_addr] && !match_2;
    assign waw    = writes_rd && pend_full[rd] && !wb_hits_rd;
    assign hazard = raw_1 || raw_2 || waw;

    assign pipe.d2e_valid = held_q && !hazard && !kill;
    assign issue          = pipe.d2e_valid && pipe.d2e_ready;
    assign pipe.f2d_ready = !kill && (!held_q || issue);
    assign accept         = pipe.f2d_valid && pipe.f2d_ready;

    assign pipe.d2e_instr    = instr_q;
    assign pipe.d2e_pc       = pc_q;
    assign pipe.d2e_rs1_data = (rs1_addr == 5'd0) ? '0 : (match_1 ? wb_rd_wdata : rs1_rdata);
    assign pipe.d2e_rs2_data = (rs2_addr == 5'd0) ? '0 : (match_2 ? wb_rd_wdata : rs2_rdata);

    // Set is applied after clear so an issue to the register being written back keeps it pending
    always_comb begin
        pending_d = pending_q;
        for (int unsigned i = 1; i < 32; i++) begin
            if (wb_rd_write && (wb_rd_addr == 5'(i)))
                pending_d[i] = 1'b0;
            if (issue && writes_rd && (rd == 5'(i)))
                pending_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            held_q    <= 1'b0;
            instr_q   <= '0;
            pc_q      <= '0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (kill) begin
                held_q <= 1'b0;
            end else if (accept) begin
                held_q  <= 1'b1;
                instr_q <= pipe.f2d_instr;
                pc_q    <= pipe.f2d_pc;
            end else if (issue) begin
                held_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_armleocpu_decode_operand.sv
// Directed bench for armleocpu_decode_operand: one instance with bypass, one without,
// sharing fetch/execute/writeback stimulus and a simple register file.
module tb_armleocpu_decode_operand;

    localparam logic [31:0] I_ADDI5  = 32'h00700293; // addi x5, x0, 7
    localparam logic [31:0] I_ADD6   = 32'h00528333; // add  x6, x5, x5
    localparam logic [31:0] I_LUI5   = 32'h123452B7; // lui  x5, 0x12345
    localparam logic [31:0] I_ADDI7  = 32'h00100393; // addi x7, x0, 1
    localparam logic [31:0] I_ADDI31 = 32'h00000F93; // addi x31, x0, 0
    localparam logic [31:0] I_UNK    = 32'hFFFFFFFF; // unknown opcode, all fields 31

    logic        clk;
    logic        async_rst_n;
    logic        kill;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_wdata;
    logic        wb_rd_write;
    logic [31:0] rf [32];

    logic [4:0]  a_rs1_addr, a_rs2_addr, b_rs1_addr, b_rs2_addr;
    logic [31:0] a_rs1_rdata, a_rs2_rdata, b_rs1_rdata, b_rs2_rdata;

    int vectors;
    int miscompares;

    armleocpu_decode_operand_if ia ();
    armleocpu_decode_operand_if ib ();

    assign ib.f2d_valid = ia.f2d_valid;
    assign ib.f2d_instr = ia.f2d_instr;
    assign ib.f2d_pc    = ia.f2d_pc;
    assign ib.d2e_ready = ia.d2e_ready;

    assign a_rs1_rdata = rf[a_rs1_addr];
    assign a_rs2_rdata = rf[a_rs2_addr];
    assign b_rs1_rdata = rf[b_rs1_addr];
    assign b_rs2_rdata = rf[b_rs2_addr];

    armleocpu_decode_operand #(.BYPASS(1'b1)) dut_a (
        .clk(clk), .async_rst_n(async_rst_n), .pipe(ia.slave),
        .rs1_addr(a_rs1_addr), .rs1_rdata(a_rs1_rdata),
        .rs2_addr(a_rs2_addr), .rs2_rdata(a_rs2_rdata),
        .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata), .wb_rd_write(wb_rd_write),
        .kill(kill)
    );

    armleocpu_decode_operand #(.BYPASS(1'b0)) dut_b (
        .clk(clk), .async_rst_n(async_rst_n), .pipe(ib.slave),
        .rs1_addr(b_rs1_addr), .rs1_rdata(b_rs1_rdata),
        .rs2_addr(b_rs2_addr), .rs2_rdata(b_rs2_rdata),
        .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata), .wb_rd_write(wb_rd_write),
        .kill(kill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one clock; the register file commits the writeback at the edge
    task automatic tick();
        @(posedge clk);
        if (wb_rd_write && wb_rd_addr != 5'd0)
            rf[wb_rd_addr] = wb_rd_wdata;
        #1;
    endtask

    task automatic idle_inputs();
        ia.f2d_valid = 1'b0;
        ia.f2d_instr = '0;
        ia.f2d_pc    = '0;
        ia.d2e_ready = 1'b0;
        kill         = 1'b0;
        wb_rd_write  = 1'b0;
        wb_rd_addr   = '0;
        wb_rd_wdata  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        for (int i = 0; i < 32; i++)
            rf[i] = 32'h100 + i;
        rf[0] = 32'hDEAD0000;
        @(posedge clk);
        #2 async_rst_n = 1'b0;
        #3 async_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        @(posedge clk);
        #2 async_rst_n = 1'b0;
        #1;
        vectors++; if (ia.d2e_valid !== 1'b0) begin miscompares++; $display("FAIL rst_d2e_valid: got %b want 0", ia.d2e_valid); end
        vectors++; if (ia.f2d_ready !== 1'b1) begin miscompares++; $display("FAIL rst_f2d_ready: got %b want 1", ia.f2d_ready); end
        vectors++; if (ia.d2e_instr !== 32'h0) begin miscompares++; $display("FAIL rst_d2e_instr: got %h want 0", ia.d2e_instr); end
        vectors++; if (ia.d2e_pc !== 32'h0) begin miscompares++; $display("FAIL rst_d2e_pc: got %h want 0", ia.d2e_pc); end
        vectors++; if (ia.d2e_rs1_data !== 32'h0 || ia.d2e_rs2_data !== 32'h0) begin miscompares++; $display("FAIL rst_operands: got %h/%h want 0/0", ia.d2e_rs1_data, ia.d2e_rs2_data); end
        vectors++; if (dut_a.pending_q !== 31'h0) begin miscompares++; $display("FAIL rst_pending: got %h want 0", dut_a.pending_q); end
        #2 async_rst_n = 1'b1;
    endtask

    task automatic test_addi_issue();
        do_reset();
        ia.f2d_valid = 1'b1; ia.f2d_instr = I_ADDI5; ia.f2d_pc = 32'h100; ia.d2e_ready = 1'b1;
        #1;
        vectors++; if (ia.f2d_ready !== 1'b1 || ia.d2e_valid !== 1'b0) begin miscompares++; $display("FAIL addi_accept: got ready=%b valid=%b want 1/0", ia.f2d_ready, ia.d2e_valid); end
        tick();
        ia.f2d_valid = 1'b0;
        #1;
        vectors++; if (ia.d2e_valid !== 1'b1) begin miscompares++; $display("FAIL addi_valid: got %b want 1", ia.d2e_valid); end
        vectors++; if (ia.d2e_instr !== I_ADDI5 || ia.d2e_pc !== 32'h100) begin miscompares++; $display("FAIL addi_instr_pc: got %h/%h want %h/100", ia.d2e_instr, ia.d2e_pc, I_ADDI5); end
        vectors++; if (ia.d2e_rs1_data !== 32'h0) begin miscompares++; $display("FAIL addi_rs1_x0: got %h want 0", ia.d2e_rs1_data); end
        vectors++; if (ia.d2e_rs2_data !== 32'h107) begin miscompares++; $display("FAIL addi_rs2_rf: got %h want 107", ia.d2e_rs2_data); end
        tick();
        vectors++; if (dut_a.pending_q[5] !== 1'b1) begin miscompares++; $display("FAIL addi_pending5: got %b want 1", dut_a.pending_q[5]); end
        vectors++; if (ia.d2e_valid !== 1'b0 || ia.f2d_ready !== 1'b1) begin miscompares++; $display("FAIL addi_drained: got valid=%b ready=%b want 0/1", ia.d2e_valid, ia.f2d_ready); end
    endtask

    task automatic test_raw_bypass();
        do_reset();
        ia.f2d_valid = 1'b1; ia.f2d_instr = I_ADDI5; ia.f2d_pc = 32'h200; ia.d2e_ready = 1'b1;
        tick();
        ia.f2d_instr = I_ADD6; ia.f2d_pc = 32'h204;
        tick();
        ia.f2d_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++; if (ia.d2e_valid !== 1'b0 || ib.d2e_valid !== 1'b0) begin miscompares++; $display("FAIL raw_stall%0d: got a=%b b=%b want 0/0", c, ia.d2e_valid, ib.d2e_valid); end
            vectors++; if (ia.f2d_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall_ready%0d: got %b want 0", c, ia.f2d_ready); end
            tick();
        end
        wb_rd_write = 1'b1; wb_rd_addr = 5'd5; wb_rd_wdata = 32'h1234;
        #1;
        vectors++; if (ia.d2e_valid !== 1'b1) begin miscompares++; $display("FAIL byp_valid: got %b want 1", ia.d2e_valid); end
        vectors++; if (ia.d2e_rs1_data !== 32'h1234 || ia.d2e_rs2_data !== 32'h1234) begin miscompares++; $display("FAIL byp_operands: got %h/%h want 1234/1234", ia.d2e_rs1_data, ia.d2e_rs2_data); end
        vectors++; if (ib.d2e_valid !== 1'b0) begin miscompares++; $display("FAIL nobyp_wb_cycle: got %b want 0", ib.d2e_valid); end
        tick();
        wb_rd_write = 1'b0;
        #1;
        vectors++; if (ib.d2e_valid !== 1'b1) begin miscompares++; $display("FAIL nobyp_valid: got %b want 1", ib.d2e_valid); end
        vectors++; if (ib.d2e_rs1_data !== 32'h1234 || ib.d2e_rs2_data !== 32'h1234) begin miscompares++; $display("FAIL nobyp_operands: got %h/%h want 1234/1234", ib.d2e_rs1_data, ib.d2e_rs2_data); end
        vectors++; if (ia.d2e_valid !== 1'b0 || ia.f2d_ready !== 1'b1) begin miscompares++; $display("FAIL byp_issued: got valid=%b ready=%b want 0/1", ia.d2e_valid, ia.f2d_ready); end
        vectors++; if (dut_a.pending_q[6] !== 1'b1 || dut_a.pending_q[5] !== 1'b0) begin miscompares++; $display("FAIL byp_pending: got p6=%b p5=%b want 1/0", dut_a.pending_q[6], dut_a.pending_q[5]); end
        tick();
    endtask

    task automatic test_waw();
        do_reset();
        ia.f2d_valid = 1'b1; ia.f2d_instr = I_ADDI5; ia.f2d_pc = 32'h300; ia.d2e_ready = 1'b1;
        tick();
        ia.f2d_instr = I_LUI5; ia.f2d_pc = 32'h304;
        tick();
        ia.f2d_valid = 1'b0;
        #1;
        vectors++; if (ia.d2e_valid !== 1'b0) begin miscompares++; $display("FAIL waw_stall: got %b want 0", ia.d2e_valid); end
        tick();
        wb_rd_write = 1'b1; wb_rd_addr = 5'd5; wb_rd_wdata = 32'hABCD;
        #1;
        vectors++; if (ia.d2e_valid !== 1'b1 || ib.d2e_valid !== 1'b1) begin miscompares++; $display("FAIL waw_release: got a=%b b=%b want 1/1", ia.d2e_valid, ib.d2e_valid); end
        vectors++; if (ia.d2e_instr !== I_LUI5) begin miscompares++; $display("FAIL waw_instr: got %h want %h", ia.d2e_instr, I_LUI5); end
        tick();
        wb_rd_write = 1'b0;
        #1;
        vectors++; if (dut_a.pending_q[5] !== 1'b1) begin miscompares++; $display("FAIL waw_set_wins: got %b want 1", dut_a.pending_q[5]); end
    endtask

    task automatic test_backpressure();
        do_reset();
        ia.f2d_valid = 1'b1; ia.f2d_instr = I_ADDI7; ia.f2d_pc = 32'h400; ia.d2e_ready = 1'b0;
        tick();
        ia.f2d_instr = I_LUI5; ia.f2d_pc = 32'h404;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if (ia.d2e_valid !== 1'b1 || ia.f2d_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold%0d: got valid=%b ready=%b want 1/0", c, ia.d2e_valid, ia.f2d_ready); end
            vectors++; if (ia.d2e_instr !== I_ADDI7 || ia.d2e_pc !== 32'h400) begin miscompares++; $display("FAIL bp_stable%0d: got %h/%h want %h/400", c, ia.d2e_instr, ia.d2e_pc, I_ADDI7); end
            vectors++; if (dut_a.pending_q !== 31'h0) begin miscompares++; $display("FAIL bp_pending%0d: got %h want 0", c, dut_a.pending_q); end
            tick();
        end
        ia.d2e_ready = 1'b1;
        #1;
        vectors++; if (ia.d2e_valid !== 1'b1 || ia.f2d_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got valid=%b ready=%b want 1/1", ia.d2e_valid, ia.f2d_ready); end
        tick();
        ia.f2d_valid = 1'b0;
        #1;
        vectors++; if (ia.d2e_instr !== I_LUI5 || ia.d2e_pc !== 32'h404) begin miscompares++; $display("FAIL bp_next: got %h/%h want %h/404", ia.d2e_instr, ia.d2e_pc, I_LUI5); end
        vectors++; if (dut_a.pending_q[7] !== 1'b1) begin miscompares++; $display("FAIL bp_pending7: got %b want 1", dut_a.pending_q[7]); end
        tick();
    endtask

    task automatic test_kill();
        do_reset();
        ia.f2d_valid = 1'b1; ia.f2d_instr = I_ADDI7; ia.f2d_pc = 32'h500; ia.d2e_ready = 1'b0;
        tick();
        kill = 1'b1; ia.f2d_instr = I_LUI5; ia.f2d_pc = 32'h600; ia.d2e_ready = 1'b1;
        #1;
        vectors++; if (ia.d2e_valid !== 1'b0 || ia.f2d_ready !== 1'b0) begin miscompares++; $display("FAIL kill_cycle: got valid=%b ready=%b want 0/0", ia.d2e_valid, ia.f2d_ready); end
        tick();
        kill = 1'b0;
        #1;
        vectors++; if (ia.d2e_valid !== 1'b0 || ia.f2d_ready !== 1'b1) begin miscompares++; $display("FAIL kill_after: got valid=%b ready=%b want 0/1", ia.d2e_valid, ia.f2d_ready); end
        vectors++; if (dut_a.pending_q[7] !== 1'b0) begin miscompares++; $display("FAIL kill_pending7: got %b want 0", dut_a.pending_q[7]); end
        tick();
        ia.f2d_valid = 1'b0;
        #1;
        vectors++; if (ia.d2e_valid !== 1'b1 || ia.d2e_instr !== I_LUI5 || ia.d2e_pc !== 32'h600) begin miscompares++; $display("FAIL kill_refill: got valid=%b %h/%h want 1 %h/600", ia.d2e_valid, ia.d2e_instr, ia.d2e_pc, I_LUI5); end
        tick();
    endtask

    task automatic test_unknown_opcode();
        do_reset();
        ia.f2d_valid = 1'b1; ia.f2d_instr = I_ADDI31; ia.f2d_pc = 32'h700; ia.d2e_ready = 1'b1;
        tick();
        ia.f2d_instr = I_UNK; ia.f2d_pc = 32'h704;
        tick();
        ia.f2d_valid = 1'b0;
        #1;
        vectors++; if (dut_a.pending_q[31] !== 1'b1) begin miscompares++; $display("FAIL unk_pending31: got %b want 1", dut_a.pending_q[31]); end
        vectors++; if (ia.d2e_valid !== 1'b1) begin miscompares++; $display("FAIL unk_no_hazard: got %b want 1", ia.d2e_valid); end
        vectors++; if (ia.d2e_rs1_data !== 32'h11F || ia.d2e_rs2_data !== 32'h11F) begin miscompares++; $display("FAIL unk_operands: got %h/%h want 11f/11f", ia.d2e_rs1_data, ia.d2e_rs2_data); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        ia.f2d_valid = 1'b1; ia.f2d_instr = I_ADDI5; ia.f2d_pc = 32'h800; ia.d2e_ready = 1'b1;
        tick();
        ia.f2d_instr = I_ADD6; ia.f2d_pc = 32'h804;
        tick();
        ia.f2d_valid = 1'b0;
        #1;
        vectors++; if (dut_a.pending_q[5] !== 1'b1 || ia.f2d_ready !== 1'b0) begin miscompares++; $display("FAIL arst_pre: got p5=%b ready=%b want 1/0", dut_a.pending_q[5], ia.f2d_ready); end
        #1 async_rst_n = 1'b0;
        #1;
        vectors++; if (dut_a.pending_q !== 31'h0) begin miscompares++; $display("FAIL arst_pending: got %h want 0", dut_a.pending_q); end
        vectors++; if (ia.d2e_valid !== 1'b0 || ia.f2d_ready !== 1'b1) begin miscompares++; $display("FAIL arst_handshake: got valid=%b ready=%b want 0/1", ia.d2e_valid, ia.f2d_ready); end
        #1 async_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        async_rst_n = 1'b1;
        idle_inputs();
        for (int i = 0; i < 32; i++)
            rf[i] = 32'h100 + i;
        test_reset();
        test_addi_issue();
        test_raw_bypass();
        test_waw();
        test_backpressure();
        test_kill();
        test_unknown_opcode();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/armleocpu_decode_operand.md
Name: armleocpu_decode_operand

Overview:
- Decode/operand-fetch stage between fetch and execute.
- Holds one instruction from fetch and drives the register file read addresses.
- Forwards the register file write port as a bypass and tracks in-flight destination registers in a scoreboard.
- Issues the instruction with resolved operands to execute over a valid/ready handshake.

Parameters:
- BYPASS, 1, 1 = writeback-port forwarding enabled; 0 = operands taken only from the register file (hazard clears one cycle later).

Ports:
- clk  input  1  clock, rising edge
- async_rst_n  input  1  asynchronous active-low reset
- f2d_valid  input  1  fetch offers an instruction
- f2d_ready  output  1  stage accepts the offered instruction
- f2d_instr  input  32  instruction word
- f2d_pc  input  32  instruction address
- rs1_addr  output  5  register file read address 1 = held instr[19:15]
- rs1_rdata  input  32  register file read data 1 (combinational)
- rs2_addr  output  5  register file read address 2 = held instr[24:20]
- rs2_rdata  input  32  register file read data 2
- wb_rd_addr  input  5  writeback destination, same signal that drives the register file
- wb_rd_wdata  input  32  writeback data
- wb_rd_write  input  1  writeback strobe
- kill  input  1  flush from execute (redirect)
- d2e_valid  output  1  issue request
- d2e_ready  input  1  execute accepts
- d2e_instr  output  32  held instruction
- d2e_pc  output  32  held pc
- d2e_rs1_data  output  32  resolved operand 1
- d2e_rs2_data  output  32  resolved operand 2

Behaviour:
- Clock and reset: clk and async_rst_n (asynchronous, active-low) are already decided.
- State:
  - held (1b), instr_q (32b), pc_q (32b).
  - pending[31:1] scoreboard; bit 0 does not exist and x0 is never pending.
- Reset values:
  - held=0, instr_q=0, pc_q=0, pending=0.
  - Outputs: d2e_valid=0, f2d_ready=1, d2e_* data=0.
- Decode of instr_q[6:0]:
  - writes_rd (rd=instr_q[11:7]): LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, SYSTEM with funct3!=0. Forced 0 when rd==0.
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM with funct3 in {1,2,3}.
  - uses_rs2: BRANCH, STORE, OP.
  - Unknown opcodes: no sources, no rd. Passed through; execute flags illegal.
- Bypass (X=1,2):
  - match_X = BYPASS && wb_rd_write && wb_rd_addr==rsX && rsX!=0.
  - d2e_rsX_data = 0 if rsX==0; wb_rd_wdata if match_X; else rsX_rdata.
- Hazard conditions:
  - raw_X = uses_rsX && pending[rsX] && !match_X.
  - waw = writes_rd && pending[rd] && !(wb_rd_write && wb_rd_addr==rd).
  - hazard = raw_1 | raw_2 | waw.
- Handshakes:
  - d2e_valid = held && !hazard && !kill.
  - issue = d2e_valid && d2e_ready.
  - f2d_ready = !kill && (!held || issue).
  - Accept on f2d_valid && f2d_ready: held<=1 and capture instr/pc. Latency: issue offered the cycle after accept at the earliest.
  - Issue without accept: held<=0.
  - d2e_* outputs stay stable while d2e_valid=1 and d2e_ready=0. Operands may change only from bypass of the same value, since no new write to a non-pending register is legal.
- Scoreboard, per cycle:
  - Clear pending[wb_rd_addr] when wb_rd_write and addr!=0.
  - Set pending[rd] when issue && writes_rd.
  - Same rd set and cleared in one cycle: set wins.
- Kill:
  - held<=0, no issue, no accept that cycle.
  - Scoreboard untouched; bits are set only on issue, so killed-before-issue instructions leave no trace.
  - Execute is responsible for writing back, or for dropping and clearing via wb with no data change, every issued instruction.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. The held instruction is lost.

Test Plan:
- ADDI x5,x0,7 accepted at cycle 0 with d2e_ready=1 → d2e_valid=1 at cycle 1 with rs1_data=0, issued; pending[5]=1 at cycle 2.
- ADD x6,x5,x5 while pending[5]=1 → d2e_valid=0. When wb writes x5=0x1234 → same cycle d2e_valid=1, both operands 0x1234; with BYPASS=0, valid appears one cycle later with register file data.
- LUI x5 with pending[5]=1 (WAW) → stall until wb x5. Issue in the wb cycle → pending[5] remains 1 (set wins).
- d2e_ready=0 for 3 cycles with held valid instruction → f2d_ready=0, d2e_instr/pc stable, no scoreboard change; 4th-cycle ready → issue and f2d_ready=1 same cycle.
- kill while holding ADDI x7 → d2e_valid=0, f2d_ready=0 that cycle; next cycle held=0, pending[7]=0, new instruction accepted.
- async_rst_n low mid-stall with pending[5]=1 → pending=0, d2e_valid=0, f2d_ready=1 immediately, without waiting for a clock edge.
